// File: rtl/single_one_search_ctrl_pkg.sv
// single_one_search_ctrl_pkg: shared widths and state encoding for the single-bit error locator
package single_one_search_ctrl_pkg;
  localparam int SYN_W   = 36;
  localparam int NUM_POS = 37;
  localparam int POS_W   = 6;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/single_one_search_ctrl_if.sv
// single_one_search_ctrl_if: checker port and result handshake of the single-bit locator
interface single_one_search_ctrl_if;
  import single_one_search_ctrl_pkg::*;
  logic [SYN_W-1:0] chk_syn;
  logic [POS_W-1:0] chk_pos;
  logic             chk_hit;
  logic             res_valid;
  logic             res_ready;
  logic             res_found;
  logic             res_zero;
  logic [POS_W-1:0] res_pos;
  modport master (
    output chk_syn, chk_pos, res_valid, res_found, res_zero, res_pos,
    input  chk_hit, res_ready
  );
  modport slave (
    input  chk_syn, chk_pos, res_valid, res_found, res_zero, res_pos,
    output chk_hit, res_ready
  );
endinterface

// File: rtl/single_one_search_ctrl_pos_counter.sv
// single_pos_counter: candidate-position up-counter with clear, enable and terminal flag
module single_pos_counter #(
  parameter int W    = 6,
  parameter int LAST = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);
  // clear wins over enable; the controller never enables past LAST
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : en ? cnt + 1'b1 : cnt;
  assign term = cnt == W'(LAST);
endmodule

// File: rtl/single_one_search_ctrl.sv
// single_one_search_ctrl: sweeps positions through an external checker and reports the first hit
module single_one_search_ctrl
  import single_one_search_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SYN_W-1:0]          s_in,
  input  logic                      abort,
  output logic                      busy,
  single_one_search_ctrl_if.master  bus
);
  state_t           state, nxt;
  logic [SYN_W-1:0] syn;
  logic [POS_W-1:0] cnt, pos;
  logic             term, cnt_clr, cnt_en, found, zero;
  logic             go, hit, miss, cancel, accept;
  assign go     = state == ST_IDLE && start;
  assign cancel = state == ST_SEARCH && abort;
  assign hit    = state == ST_SEARCH && !abort && bus.chk_hit;
  assign miss   = state == ST_SEARCH && !abort && !bus.chk_hit && term;
  assign accept = state == ST_DONE && bus.res_ready;
  single_pos_counter #(.W(POS_W), .LAST(NUM_POS - 1)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .term (term)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= nxt;
  // next state and counter control; abort outranks a same-cycle hit
  always_comb begin
    nxt     = state;
    cnt_clr = state == ST_IDLE || cancel || accept;
    cnt_en  = state == ST_SEARCH && !abort && !bus.chk_hit && !term;
    nxt     = go ? (|s_in ? ST_SEARCH : ST_DONE) :
              (cancel || accept) ? ST_IDLE :
              (hit || miss) ? ST_DONE : state;
  end
  // latched syndrome and result fields, held stable through DONE until accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      syn   <= '0;
      found <= 1'b0;
      zero  <= 1'b0;
      pos   <= '0;
    end else if (go) begin
      syn   <= s_in;
      found <= ~|s_in;
      zero  <= ~|s_in;
      pos   <= '0;
    end else if (hit) begin
      found <= 1'b1;
      pos   <= cnt;
    end else if (accept || cancel) begin
      syn   <= '0;
      found <= 1'b0;
      zero  <= 1'b0;
      pos   <= '0;
    end
  assign busy          = state != ST_IDLE;
  assign bus.chk_syn   = state == ST_SEARCH ? syn : '0;
  assign bus.chk_pos   = state == ST_SEARCH ? cnt : '0;
  assign bus.res_valid = state == ST_DONE;
  assign bus.res_found = found;
  assign bus.res_zero  = zero;
  assign bus.res_pos   = pos;
endmodule

// File: tb/tb_single_one_search_ctrl.sv
// tb_single_one_search_ctrl: directed checks of the single-bit locator with a bench-side checker model
module tb_single_one_search_ctrl;
  import single_one_search_ctrl_pkg::*;
  logic             clk = 0;
  logic             rst_n = 0;
  logic             start = 0;
  logic             abort = 0;
  logic [SYN_W-1:0] s_in = '0;
  logic             busy;
  logic             hit_en = 0;
  logic [POS_W-1:0] hit_pos = '0;
  int               n = 0;
  int               fails = 0;
  single_one_search_ctrl_if bus ();
  assign bus.chk_hit = hit_en && bus.chk_pos == hit_pos;
  single_one_search_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .s_in (s_in),
    .abort(abort),
    .busy (busy),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_start(input logic [SYN_W-1:0] s);
    start = 1;
    s_in = s;
    step();
    start = 0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_syn"}, 64'(bus.chk_syn), 0);
    chk({tag, "_pos"}, 64'(bus.chk_pos), 0);
    chk({tag, "_valid"}, 64'(bus.res_valid), 0);
    chk({tag, "_found"}, 64'(bus.res_found), 0);
    chk({tag, "_zero"}, 64'(bus.res_zero), 0);
    chk({tag, "_rpos"}, 64'(bus.res_pos), 0);
  endtask
  initial begin
    logic seen;
    bus.res_ready = 0;
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1;
    // hit at position 5
    hit_en = 1;
    hit_pos = 5;
    do_start(36'h123456789);
    chk("hit_busy", 64'(busy), 1);
    chk("hit_syn", 64'(bus.chk_syn), 64'h123456789);
    chk("hit_pos0", 64'(bus.chk_pos), 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("hit_sweep", 64'(bus.chk_pos), 64'(k));
      chk("hit_novalid", 64'(bus.res_valid), 0);
    end
    step();
    chk("hit_valid", 64'(bus.res_valid), 1);
    chk("hit_found", 64'(bus.res_found), 1);
    chk("hit_rpos", 64'(bus.res_pos), 5);
    chk("hit_zero", 64'(bus.res_zero), 0);
    chk("hit_chkpos_done", 64'(bus.chk_pos), 0);
    chk("hit_chksyn_done", 64'(bus.chk_syn), 0);
    bus.res_ready = 1;
    step();
    bus.res_ready = 0;
    chk_all_zero("hit_acc");
    // full miss
    hit_en = 0;
    do_start(36'h800000001);
    for (int k = 1; k <= 36; k++) begin
      step();
      chk("miss_sweep", 64'(bus.chk_pos), 64'(k));
      chk("miss_novalid", 64'(bus.res_valid), 0);
    end
    step();
    chk("miss_valid", 64'(bus.res_valid), 1);
    chk("miss_found", 64'(bus.res_found), 0);
    chk("miss_rpos", 64'(bus.res_pos), 0);
    chk("miss_chkpos", 64'(bus.chk_pos), 0);
    bus.res_ready = 1;
    step();
    bus.res_ready = 0;
    chk_all_zero("miss_acc");
    // zero syndrome
    do_start('0);
    chk("zero_valid", 64'(bus.res_valid), 1);
    chk("zero_zero", 64'(bus.res_zero), 1);
    chk("zero_found", 64'(bus.res_found), 1);
    chk("zero_rpos", 64'(bus.res_pos), 0);
    chk("zero_chkpos", 64'(bus.chk_pos), 0);
    chk("zero_busy", 64'(busy), 1);
    bus.res_ready = 1;
    step();
    bus.res_ready = 0;
    chk_all_zero("zero_acc");
    // backpressure, start while busy, same-edge accept and start
    hit_en = 1;
    hit_pos = 2;
    do_start(36'hA5A5A5A5A);
    start = 1;
    s_in = 36'h111;
    step();
    start = 0;
    chk("bp_syn_kept", 64'(bus.chk_syn), 64'hA5A5A5A5A);
    chk("bp_pos1", 64'(bus.chk_pos), 1);
    step();
    chk("bp_pos2", 64'(bus.chk_pos), 2);
    step();
    for (int i = 0; i < 8; i++) begin
      start = i == 3;
      step();
      chk("bp_valid", 64'(bus.res_valid), 1);
      chk("bp_found", 64'(bus.res_found), 1);
      chk("bp_rpos", 64'(bus.res_pos), 2);
    end
    start = 0;
    bus.res_ready = 1;
    start = 1;
    s_in = 36'h777;
    step();
    bus.res_ready = 0;
    chk("bp_acc_busy", 64'(busy), 0);
    chk("bp_acc_valid", 64'(bus.res_valid), 0);
    step();
    start = 0;
    chk("bp_restart_busy", 64'(busy), 1);
    chk("bp_restart_syn", 64'(bus.chk_syn), 64'h777);
    chk("bp_restart_pos", 64'(bus.chk_pos), 0);
    abort = 1;
    step();
    abort = 0;
    chk_all_zero("bp_abort");
    // abort beats a same-cycle hit at position 3
    hit_pos = 3;
    do_start(36'h5);
    step();
    step();
    step();
    chk("ab_pos3", 64'(bus.chk_pos), 3);
    abort = 1;
    step();
    abort = 0;
    chk_all_zero("ab");
    step();
    step();
    chk("ab_novalid", 64'(bus.res_valid), 0);
    hit_pos = 1;
    do_start(36'h9);
    chk("ab_fresh_pos0", 64'(bus.chk_pos), 0);
    step();
    chk("ab_fresh_pos1", 64'(bus.chk_pos), 1);
    step();
    chk("ab_fresh_valid", 64'(bus.res_valid), 1);
    chk("ab_fresh_rpos", 64'(bus.res_pos), 1);
    abort = 1;
    step();
    abort = 0;
    chk("done_abort_ign", 64'(bus.res_valid), 1);
    chk("done_abort_rpos", 64'(bus.res_pos), 1);
    bus.res_ready = 1;
    step();
    bus.res_ready = 0;
    chk_all_zero("ab_acc");
    // asynchronous reset mid-search
    hit_en = 0;
    do_start(36'hF0);
    repeat (10) step();
    chk("rs_pos10", 64'(bus.chk_pos), 10);
    #2 rst_n = 0;
    #1;
    chk_all_zero("rs_async");
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (40) begin
      step();
      seen |= bus.res_valid | busy;
    end
    chk("rs_no_result", 64'(seen), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
